// File: rtl/ram_access_ctrl_if.sv
// rtl/ram_access_ctrl_if.sv - Request/response handshake bundle between datapath and RAM controller.
interface ram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - Load/store initiator driving the on-chip RAM port.
// Defining WRITE_VERIFY_EN adds a read-back check after every store.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  ram_access_ctrl_if.slave      bus,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RWAIT,
    WR,
    RESP
`ifdef WRITE_VERIFY_EN
    , VRD,
    VWAIT
`endif
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic                  cnt_last;
  logic                  waiting;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign cnt_last = (cnt == CNT_LAST);
  assign accept   = (state == IDLE) && bus.req_valid;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Strobes are decoded from state only, so a reset drops them on the same edge.
  always_comb begin
    state_next     = state;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    waiting        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = bus.req_write ? WR : RD;
      end
      RD: begin
        mem_read   = 1'b1;
        state_next = RWAIT;
      end
      RWAIT: begin
        waiting = 1'b1;
        if (cnt_last) state_next = RESP;
      end
      WR: begin
        mem_write = 1'b1;
`ifdef WRITE_VERIFY_EN
        state_next = VRD;
`else
        state_next = RESP;
`endif
      end
`ifdef WRITE_VERIFY_EN
      VRD: begin
        mem_read   = 1'b1;
        state_next = VWAIT;
      end
      VWAIT: begin
        waiting = 1'b1;
        if (cnt_last) state_next = RESP;
      end
`endif
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      mem_address <= '0;
      mem_data_in <= '0;
      rdata_q     <= '0;
      cnt         <= '0;
    end else begin
      if (accept) begin
        mem_address <= bus.req_addr;
        mem_data_in <= bus.req_wdata;
      end
      if (waiting) cnt <= cnt_last ? '0 : cnt + CW'(1);
      if (waiting && cnt_last) rdata_q <= mem_data_out;
    end
  end

  assign bus.resp_rdata = rdata_q;

`ifdef WRITE_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (clear)                          err_q <= 1'b0;
    else if (accept)                    err_q <= 1'b0;
    else if (state == VWAIT && cnt_last) err_q <= (mem_data_out != mem_data_in);
  end

  assign bus.resp_err = err_q;
`else
  assign bus.resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - Randomized bench for ram_access_ctrl against a word-array reference.
module tb_ram_access_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int RL = 1;
`ifdef WRITE_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          clear;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  ram_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .clk          (clk),
    .clear        (clear),
    .bus          (bus_if),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // RAM with registered read; the verify build stores 0x10 with bit 0 flipped.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] pipe [0:RL-1];
  bit            ram_ready = 1'b0;

  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < (1 << AW); i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_write) begin
      ram[mem_address] <= (VERIFY && mem_data_in == 32'h10) ? (mem_data_in | 32'h1) : mem_data_in;
    end
    pipe[0] <= ram[mem_address];
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_data_out = pipe[RL-1];

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int hold);
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] stored;
    bit            exp_err;
    bit            chk_rdata;
    int            exp_lat, resp_cyc, rd_pulses, wr_pulses, guard;
    exp_err   = 1'b0;
    chk_rdata = 1'b1;
    if (wr) begin
      stored = (VERIFY && wdata == 32'h10) ? (wdata | 32'h1) : wdata;
      ref_mem[addr] = stored;
      exp_rdata = stored;
      exp_err   = VERIFY && (stored != wdata);
      exp_lat   = VERIFY ? RL + 3 : 2;
      chk_rdata = VERIFY;
    end else begin
      exp_rdata = ref_mem[addr];
      exp_lat   = RL + 2;
    end

    bus_if.req_valid = 1'b1;
    bus_if.req_write = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    guard = 0;
    while (!bus_if.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("accept_timeout", 32'(guard), 32'd0);
      bus_if.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus_if.req_valid = 1'b0;

    resp_cyc  = 0;
    rd_pulses = 0;
    wr_pulses = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      check("rw_excl", 32'(mem_read & mem_write), 32'd0);
      if (mem_read) begin
        rd_pulses++;
        check("rd_addr", 32'(mem_address), 32'(addr));
      end
      if (mem_write) begin
        wr_pulses++;
        check("wr_addr", 32'(mem_address), 32'(addr));
        check("wr_data", mem_data_in, wdata);
      end
      if (bus_if.resp_valid) begin
        resp_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("resp_latency", 32'(resp_cyc), 32'(exp_lat));
    check("rd_pulses", 32'(rd_pulses), (wr && !VERIFY) ? 32'd0 : 32'd1);
    check("wr_pulses", 32'(wr_pulses), wr ? 32'd1 : 32'd0);
    if (resp_cyc == 0) return;
    if (chk_rdata) check("resp_rdata", bus_if.resp_rdata, exp_rdata);
    check("resp_err", 32'(bus_if.resp_err), 32'(exp_err));

    // Backpressure: a competing request must be ignored while the response waits.
    for (int h = 0; h < hold; h++) begin
      bus_if.req_valid = 1'b1;
      bus_if.req_write = 1'($urandom_range(0, 1));
      bus_if.req_addr  = ~addr;
      bus_if.req_wdata = $urandom;
      @(negedge clk);
      check("hold_valid", 32'(bus_if.resp_valid), 32'd1);
      check("hold_ready", 32'(bus_if.req_ready), 32'd0);
      check("hold_addr", 32'(mem_address), 32'(addr));
      check("hold_strobes", 32'(mem_read | mem_write), 32'd0);
      if (chk_rdata) check("hold_rdata", bus_if.resp_rdata, exp_rdata);
      check("hold_err", 32'(bus_if.resp_err), 32'(exp_err));
    end
    bus_if.resp_ready = 1'b1;
    @(negedge clk);
    bus_if.resp_ready = 1'b0;
    bus_if.req_valid  = 1'b0;
    check("back_idle", 32'(bus_if.req_ready), 32'd1);
    check("resp_drop", 32'(bus_if.resp_valid), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            w;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_word(i);
    clear             = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_write  = 1'b0;
    bus_if.req_addr   = '0;
    bus_if.req_wdata  = '0;
    bus_if.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
    check("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_wdata", mem_data_in, 32'd0);
    check("rst_rdata", bus_if.resp_rdata, 32'd0);
    check("rst_err", 32'(bus_if.resp_err), 32'd0);
    clear = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 9'h090, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 9'h090, '0, 0);
    run_txn(1'b0, 9'h090, '0, 5);

    // Reset during the read wait abandons the load with no response.
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = 9'h0F7;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    check("clr_rd_pulse", 32'(mem_read), 32'd1);
    @(negedge clk);
    check("clr_rwait_rd", 32'(mem_read), 32'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_idle", 32'(bus_if.req_ready), 32'd1);
    check("clr_addr", 32'(mem_address), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("clr_no_resp", 32'(bus_if.resp_valid), 32'd0);
      check("clr_no_rd", 32'(mem_read | mem_write), 32'd0);
      @(negedge clk);
    end
    run_txn(1'b0, 9'h0F7, '0, 0);

    run_txn(1'b1, 9'h000, 32'h0123_4567, 1);
    run_txn(1'b1, 9'h1FF, 32'hFEDC_BA98, 0);
    run_txn(1'b0, 9'h000, '0, 0);
    run_txn(1'b0, 9'h1FF, '0, 2);
    run_txn(1'b1, 9'h055, 32'h0000_0010, 0);
    run_txn(1'b0, 9'h055, '0, 0);

    for (int n = 0; n < 200; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 9'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = 9'h1FF - a;
      d = ($urandom_range(0, 9) == 0) ? 32'h10 : $urandom;
      run_txn(w, a, d, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
